handshake_constant_seq: RTL and testbench
=========================================

HANDSHAKE_CONSTANT_SEQ -- requirements
Module: handshake_constant_seq

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the output data width in bits.
REQ-002 The block SHALL have parameter BASE, default 0, the first value of each sequence period.
REQ-003 The block SHALL have parameter STEP, default 1, the increment between consecutive values.
REQ-004 The block SHALL have parameter PERIOD, default 4, the number of values per period (legal range 1 to 2^16).
REQ-005 Port clk, input, 1, the single clock; all logic SHALL be rising-edge clk.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port ctrl_valid, input, 1, control token offered.
REQ-008 Port ctrl_ready, output, 1, block can accept a control token.
REQ-009 Port outs, output, DATA_WIDTH, sequence value.
REQ-010 Port outs_valid, output, 1, outs holds a valid token.
REQ-011 Port outs_ready, input, 1, consumer accepts the token.

Function
REQ-012 A control token SHALL be accepted on a cycle with ctrl_valid and ctrl_ready both high.
REQ-013 The Nth accepted token (N from 0 since reset) SHALL produce exactly one output token of value (BASE + (N mod PERIOD)*STEP) mod 2^DATA_WIDTH.
REQ-014 Values SHALL be generated by a running accumulator (add STEP, reload BASE after index PERIOD-1), not by a multiplier.
REQ-015 Output tokens SHALL leave in acceptance order, with none lost or duplicated.
REQ-016 The output path SHALL be a two-entry skid buffer (main and skid registers); outs and outs_valid SHALL be driven directly from the main register.
REQ-017 ctrl_ready SHALL be a registered signal equal to NOT skid-full, with no combinational path from outs_ready or ctrl_valid.
REQ-018 Latency SHALL be one cycle: a token accepted into an empty buffer appears on outs the next cycle.
REQ-019 Sustained throughput SHALL be one token per cycle while outs_ready stays high.
REQ-020 When main is full, outs_ready is low and a token is accepted, the token SHALL go to the skid register and ctrl_ready SHALL be low the next cycle.
REQ-021 When the skid register is full and outs_ready is high, the skid entry SHALL move to main and ctrl_ready SHALL be high the next cycle.
REQ-022 When a token is accepted on the same cycle the main entry is consumed and skid is empty, the new token SHALL load main directly.
REQ-023 While outs_valid is high and outs_ready is low, outs SHALL hold stable.
REQ-024 With PERIOD equal to 1, every token SHALL carry BASE.
REQ-025 The index and accumulator SHALL advance only on acceptance, never on output handshakes.

Reset
REQ-026 While rst is high: outs_valid 0, outs 0, ctrl_ready 0, skid empty, index 0, accumulator BASE.
REQ-027 ctrl_ready SHALL be 1 on the first cycle after rst is released.
REQ-028 Reset asserted mid-operation SHALL discard buffered tokens and restart the sequence at BASE.

Configuration
REQ-029 With macro HANDSHAKE_CONSTANT_SEQ_LAST_EN defined, the block SHALL add output port outs_last (1 bit), high with a token whose index equals PERIOD-1 and travelling through the buffer with it.
REQ-030 Without HANDSHAKE_CONSTANT_SEQ_LAST_EN, outs_last and its storage SHALL be absent; all other behaviour is unchanged.

Verification
REQ-031 DATA_WIDTH=8, BASE=10, STEP=3, PERIOD=3; 4 tokens, outs_ready=1 -> outs 10,13,16,10, each one cycle after acceptance.
REQ-032 DATA_WIDTH=8, BASE=250, STEP=10, PERIOD=4 -> outs 250,4,14,24,250 (mod-256 wrap).
REQ-033 ctrl_valid=1 continuously, outs_ready=0 for 4 cycles, then 1 -> exactly 2 accepts; ctrl_ready low from the cycle after the 2nd accept until the first drain; order preserved; then 1 token per cycle.
REQ-034 Defaults; accept 2 tokens (0,1 emitted), pulse rst 1 cycle with a token buffered -> outs_valid 0, next token outputs 0.
REQ-035 PERIOD=1, BASE=0x5A, DATA_WIDTH=8, 5 tokens -> five tokens of 0x5A; with the LAST macro enabled, outs_last=1 on every token.
REQ-036 LAST macro enabled, PERIOD=3, 6 tokens with random outs_ready -> outs_last high on tokens 3 and 6 only.

Source files
------------

// File: rtl/handshake_constant_seq.sv
// Emits BASE, BASE+STEP, ... (wrapping after PERIOD values), one value per accepted
// control token, through a two-entry skid buffer. Define HANDSHAKE_CONSTANT_SEQ_LAST_EN to add outs_last.
module handshake_constant_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int BASE       = 0,
  parameter int STEP       = 1,
  parameter int PERIOD     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ctrl_valid,
  output logic                  ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
  output logic                  outs_last,
`endif
  input  logic                  outs_ready
);

  localparam int IDX_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(PERIOD - 1);
  localparam logic [DATA_WIDTH-1:0] BASE_V   = DATA_WIDTH'(BASE);
  localparam logic [DATA_WIDTH-1:0] STEP_V   = DATA_WIDTH'(STEP);

  // A token is the data value, plus its last flag when that feature is built in.
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
  localparam int TOK_W = DATA_WIDTH + 1;
`else
  localparam int TOK_W = DATA_WIDTH;
`endif

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [TOK_W-1:0]      main_tok_q, main_tok_d;
  logic                  main_valid_q, main_valid_d;
  logic [TOK_W-1:0]      skid_tok_q, skid_tok_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  ctrl_ready_q, ctrl_ready_d;

  logic                  accept;
  logic                  consume;
  logic                  at_last;
  logic [TOK_W-1:0]      new_tok;

  always_comb begin
    accept  = ctrl_valid && ctrl_ready_q;
    consume = main_valid_q && outs_ready;
    at_last = (idx_q == LAST_IDX);
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    new_tok = {at_last, acc_q};
`else
    new_tok = acc_q;
`endif

    idx_d = idx_q;
    acc_d = acc_q;
    if (accept) begin
      if (at_last) begin
        idx_d = '0;
        acc_d = BASE_V;
      end else begin
        idx_d = idx_q + IDX_W'(1);
        acc_d = acc_q + STEP_V;
      end
    end

    main_tok_d   = main_tok_q;
    main_valid_d = main_valid_q;
    skid_tok_d   = skid_tok_q;
    skid_valid_d = skid_valid_q;
    // ctrl_ready is low whenever skid is full, so no accept can coincide with it.
    if (skid_valid_q) begin
      if (consume) begin
        main_tok_d   = skid_tok_q;
        skid_valid_d = 1'b0;
      end
    end else if (!main_valid_q || consume) begin
      main_valid_d = accept;
      if (accept) begin
        main_tok_d = new_tok;
      end
    end else if (accept) begin
      skid_tok_d   = new_tok;
      skid_valid_d = 1'b1;
    end

    ctrl_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      acc_q        <= BASE_V;
      main_tok_q   <= '0;
      main_valid_q <= 1'b0;
      skid_tok_q   <= '0;
      skid_valid_q <= 1'b0;
      ctrl_ready_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      main_tok_q   <= main_tok_d;
      main_valid_q <= main_valid_d;
      skid_tok_q   <= skid_tok_d;
      skid_valid_q <= skid_valid_d;
      ctrl_ready_q <= ctrl_ready_d;
    end
  end

  assign ctrl_ready = ctrl_ready_q;
  assign outs       = main_tok_q[DATA_WIDTH-1:0];
  assign outs_valid = main_valid_q;
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
  assign outs_last  = main_tok_q[DATA_WIDTH];
`endif

endmodule

// File: tb/tb_handshake_constant_seq.sv
// Four differently-parameterised sequence generators driven by shared stimulus,
// each checked against an arithmetic sequence formula feeding a depth-2 FIFO model.
module tb_handshake_constant_seq;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_valid;
  logic        outs_ready;
  logic        ready_w [NI];
  logic        valid_w [NI];
  logic [31:0] outs_w  [NI];
  logic [7:0]  o8      [NI];
  logic [31:0] o32;
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
  logic        last_w  [NI];
`endif

  always #5 clk = ~clk;

  handshake_constant_seq #(.DATA_WIDTH(8), .BASE(10), .STEP(3), .PERIOD(3)) u_a (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ready_w[0]),
    .outs(o8[0]), .outs_valid(valid_w[0]),
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    .outs_last(last_w[0]),
`endif
    .outs_ready(outs_ready));

  handshake_constant_seq #(.DATA_WIDTH(8), .BASE(250), .STEP(10), .PERIOD(4)) u_b (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ready_w[1]),
    .outs(o8[1]), .outs_valid(valid_w[1]),
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    .outs_last(last_w[1]),
`endif
    .outs_ready(outs_ready));

  handshake_constant_seq u_c (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ready_w[2]),
    .outs(o32), .outs_valid(valid_w[2]),
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    .outs_last(last_w[2]),
`endif
    .outs_ready(outs_ready));

  handshake_constant_seq #(.DATA_WIDTH(8), .BASE(90), .STEP(1), .PERIOD(1)) u_d (
    .clk(clk), .rst(rst), .ctrl_valid(ctrl_valid), .ctrl_ready(ready_w[3]),
    .outs(o8[3]), .outs_valid(valid_w[3]),
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
    .outs_last(last_w[3]),
`endif
    .outs_ready(outs_ready));

  assign outs_w[0] = {24'd0, o8[0]};
  assign outs_w[1] = {24'd0, o8[1]};
  assign outs_w[2] = o32;
  assign outs_w[3] = {24'd0, o8[3]};
  assign o8[2]     = 8'd0;

  int base_t [NI];
  int step_t [NI];
  int per_t  [NI];
  int dw_t   [NI];

  // Reference state: buffered tokens in order, accepted count, ready enable.
  logic [32:0] mq   [NI][2];
  int          mcnt [NI];
  int          mn   [NI];
  bit          mrdy [NI];

  logic [31:0] log0[$];
  logic [31:0] log1[$];
  logic [31:0] log3[$];
  int n_acc0;
  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  bit in_rst;

  function automatic logic [31:0] expv(int i, int n);
    longint      v;
    logic [63:0] m;
    v = longint'(base_t[i]) + longint'(n % per_t[i]) * longint'(step_t[i]);
    m = 64'(v);
    if (dw_t[i] == 32) return m[31:0];
    return m[31:0] & ((32'd1 << dw_t[i]) - 32'd1);
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    bit acc;
    bit lst;
    for (int i = 0; i < NI; i++) begin
      if (!rst && valid_w[i] && outs_ready) begin
        if (i == 0) log0.push_back(outs_w[i]);
        if (i == 1) log1.push_back(outs_w[i]);
        if (i == 3) log3.push_back(outs_w[i]);
      end
    end
    if (!rst && ctrl_valid && ready_w[0]) n_acc0++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        mcnt[i] = 0;
        mn[i]   = 0;
        mrdy[i] = 1'b0;
      end else begin
        acc = ctrl_valid && mrdy[i] && (mcnt[i] < 2);
        if (mcnt[i] > 0 && outs_ready) begin
          mq[i][0] = mq[i][1];
          mcnt[i]--;
        end
        if (acc) begin
          lst = ((mn[i] % per_t[i]) == per_t[i] - 1);
          mq[i][mcnt[i]] = {lst, expv(i, mn[i])};
          mcnt[i]++;
          mn[i]++;
        end
        mrdy[i] = 1'b1;
      end
    end
    in_rst = rst;
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("outs_valid[%0d]", i), 32'(valid_w[i]), 32'(mcnt[i] > 0));
      chk($sformatf("ctrl_ready[%0d]", i), 32'(ready_w[i]), 32'(mrdy[i] && mcnt[i] < 2));
      if (mcnt[i] > 0) begin
        chk($sformatf("outs[%0d]", i), outs_w[i], mq[i][0][31:0]);
`ifdef HANDSHAKE_CONSTANT_SEQ_LAST_EN
        chk($sformatf("outs_last[%0d]", i), 32'(last_w[i]), 32'(mq[i][0][32]));
`endif
      end else if (in_rst) begin
        chk($sformatf("outs_rst[%0d]", i), outs_w[i], 32'd0);
      end
    end
  endtask

  initial begin
    logic [31:0] e0 [4];
    logic [31:0] e1 [5];
    base_t = '{10, 250, 0, 90};
    step_t = '{3, 10, 1, 1};
    per_t  = '{3, 4, 4, 1};
    dw_t   = '{8, 8, 32, 8};
    for (int i = 0; i < NI; i++) begin
      mcnt[i] = 0;
      mn[i]   = 0;
      mrdy[i] = 1'b0;
    end
    n_acc0 = 0;

    // Reset state, then ready on the first cycle after release.
    rst = 1'b1; ctrl_valid = 1'b0; outs_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Free-running sequence: 5 back-to-back tokens with the consumer always ready.
    ctrl_valid = 1'b1; outs_ready = 1'b1;
    repeat (5) tick();
    ctrl_valid = 1'b0;
    repeat (2) tick();
    e0 = '{32'd10, 32'd13, 32'd16, 32'd10};
    e1 = '{32'd250, 32'd4, 32'd14, 32'd24, 32'd250};
    for (int k = 0; k < 4; k++) chk($sformatf("seq_a[%0d]", k), log0[k], e0[k]);
    for (int k = 0; k < 5; k++) chk($sformatf("seq_b[%0d]", k), log1[k], e1[k]);
    chk("seq_d_len", 32'(log3.size()), 32'd5);
    for (int k = 0; k < 5; k++) chk($sformatf("seq_d[%0d]", k), log3[k], 32'h5A);

    // Backpressure: only two tokens fit while the consumer stalls.
    n_acc0 = 0;
    ctrl_valid = 1'b1; outs_ready = 1'b0;
    repeat (4) tick();
    chk("stall_accepts", 32'(n_acc0), 32'd2);
    outs_ready = 1'b1;
    repeat (4) tick();
    ctrl_valid = 1'b0;
    repeat (3) tick();

    // Reset with a token buffered discards it and restarts at BASE.
    ctrl_valid = 1'b1; outs_ready = 1'b0;
    tick();
    rst = 1'b1; ctrl_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    ctrl_valid = 1'b1; outs_ready = 1'b1;
    tick();
    chk("post_rst_valid", 32'(valid_w[2]), 32'd1);
    chk("post_rst_value", outs_w[2], 32'd0);
    ctrl_valid = 1'b0;
    tick();

    // Randomised traffic with occasional resets.
    for (int t = 0; t < 300; t++) begin
      rst        = ($urandom_range(0, 63) == 0);
      ctrl_valid = ($urandom_range(0, 3) != 0);
      outs_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    rst = 1'b0; ctrl_valid = 1'b0; outs_ready = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
